uart_fifo_loopback: RTL

- Parametrised successor to the single-byte UART loopback test.
- RX bytes go into a DEPTH-entry FIFO. A TX scheduler drains the FIFO into the transmitter, so back-to-back bursts and differing RX/TX baud rates are absorbed without loss until the FIFO is full.
- LEDs show a selectable view: last byte, fill level, or status flags.
- Used on the iCE40HX-8K board to characterise maximum sustainable baud and burst length.

---
 rtl/uart_fifo_loopback_pkg.sv | 39 +++
 rtl/async_receiver.sv | 48 ++++
 rtl/async_transmitter.sv | 37 +++
 rtl/uart_fifo_loopback_fifo.sv | 53 +++++
 rtl/uart_fifo_loopback.sv | 108 ++++++++++
 5 files changed

// File: rtl/uart_fifo_loopback_pkg.sv
// Shared types and constants for the UART FIFO loopback.
// The ASCII ranges and case_swap() are only used when LOOPBACK_CASE_SWAP_EN is defined.
package uart_fifo_loopback_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } tx_state_t;

  localparam logic [1:0] LED_LAST   = 2'd0;
  localparam logic [1:0] LED_COUNT  = 2'd1;
  localparam logic [1:0] LED_STATUS = 2'd2;
  localparam logic [1:0] LED_PEEK   = 2'd3;

  localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
  localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
  localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;

  function automatic logic [7:0] case_swap(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if ((b >= ASCII_UPPER_LO && b <= ASCII_UPPER_HI) ||
        (b >= ASCII_LOWER_LO && b <= ASCII_LOWER_HI))
      r = b ^ 8'h20;
    return r;
  endfunction

  // The board wires led[0] to the MSB of the displayed value.
  function automatic logic [7:0] bit_reverse(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/async_receiver.sv
// 8N1 UART receiver, mid-bit sampling, no reset (a frame in progress always completes).
module async_receiver #(
  parameter int CLK_FREQUENCY = 12_000_000,
  parameter int BAUD          = 115_200
) (
  input  logic       clk_12mhz,
  input  logic       rxd,
  output logic       data_ready,
  output logic [7:0] data
);
  localparam int CPB = CLK_FREQUENCY / BAUD;
  localparam logic [15:0] FIRST_SAMPLE = 16'(CPB + CPB / 2 - 1);
  localparam logic [15:0] BIT_RELOAD   = 16'(CPB - 1);

  // Synchroniser stored inverted so power-up zeros read as an idle (high) line.
  logic [1:0]  sync_inv;
  logic        line;
  logic        active;
  logic [15:0] cnt;
  logic [3:0]  bit_idx;
  logic [7:0]  shift;

  assign line = ~sync_inv[1];

  always_ff @(posedge clk_12mhz) begin
    sync_inv   <= {sync_inv[0], ~rxd};
    data_ready <= 1'b0;
    if (!active) begin
      if (!line) begin
        active  <= 1'b1;
        cnt     <= FIRST_SAMPLE;
        bit_idx <= 4'd0;
      end
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end else if (bit_idx != 4'd8) begin
      shift   <= {line, shift[7:1]};
      bit_idx <= bit_idx + 4'd1;
      cnt     <= BIT_RELOAD;
    end else begin
      active <= 1'b0;
      if (line) begin
        data_ready <= 1'b1;
        data       <= shift;
      end
    end
  end
endmodule

// File: rtl/async_transmitter.sv
// 8N1 UART transmitter, no reset; busy is high for the whole 10-bit frame.
module async_transmitter #(
  parameter int CLK_FREQUENCY = 12_000_000,
  parameter int BAUD          = 115_200
) (
  input  logic       clk_12mhz,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);
  localparam logic [15:0] BIT_RELOAD = 16'(CLK_FREQUENCY / BAUD - 1);

  // Frame held inverted so an all-zero power-up register drives an idle line.
  logic [9:0]  shift_inv;
  logic [3:0]  bits_left;
  logic [15:0] cnt;

  assign busy = (bits_left != 4'd0);
  assign txd  = ~shift_inv[0];

  always_ff @(posedge clk_12mhz) begin
    if (!busy) begin
      if (start) begin
        shift_inv <= ~{1'b1, data, 1'b0};
        bits_left <= 4'd10;
        cnt       <= BIT_RELOAD;
      end
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end else begin
      shift_inv <= {1'b0, shift_inv[9:1]};
      bits_left <= bits_left - 4'd1;
      cnt       <= BIT_RELOAD;
    end
  end
endmodule

// File: rtl/uart_fifo_loopback_fifo.sv
// DEPTH-entry byte FIFO; a push while full is still accepted if a pop happens in the same cycle.
module loopback_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_12mhz,
  input  logic              reset_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  pop_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk_12mhz) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_fifo_loopback.sv
// UART echo through a FIFO with a TX scheduler FSM and a selectable LED view.
// Define LOOPBACK_CASE_SWAP_EN to swap ASCII letter case on the way out.
module uart_fifo_loopback
  import uart_fifo_loopback_pkg::*;
#(
  parameter int CLK_FREQUENCY = 12_000_000,
  parameter int RX_BAUD       = 115_200,
  parameter int TX_BAUD       = 115_200,
  parameter int DEPTH         = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic       clk_12mhz,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic [1:0] led_mode,
  output logic       txd,
  output logic [7:0] led,
  output logic       overflow
);
  logic            rx_ready;
  logic [7:0]      rx_data;
  logic            tx_start;
  logic            tx_busy;
  logic [7:0]      tx_byte;
  logic [7:0]      pop_data;
  logic [ADDR_W:0] count;
  logic            full;
  logic            empty;
  logic [7:0]      last_rx;
  logic [7:0]      shown;
  tx_state_t       state;

  async_receiver #(.CLK_FREQUENCY(CLK_FREQUENCY), .BAUD(RX_BAUD)) u_rx (
    .clk_12mhz (clk_12mhz),
    .rxd       (rxd),
    .data_ready(rx_ready),
    .data      (rx_data)
  );

  async_transmitter #(.CLK_FREQUENCY(CLK_FREQUENCY), .BAUD(TX_BAUD)) u_tx (
    .clk_12mhz(clk_12mhz),
    .start    (tx_start),
    .data     (tx_byte),
    .txd      (txd),
    .busy     (tx_busy)
  );

  loopback_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk_12mhz(clk_12mhz),
    .reset_n  (reset_n),
    .push     (rx_ready),
    .push_data(rx_data),
    .pop      (state == LOAD),
    .pop_data (pop_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  // tx_start is set on leaving LOAD, so it is high for exactly the START cycle.
  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (!empty && !tx_busy) state <= LOAD;
        LOAD: begin
`ifdef LOOPBACK_CASE_SWAP_EN
          tx_byte <= case_swap(pop_data);
`else
          tx_byte <= pop_data;
`endif
          tx_start <= 1'b1;
          state    <= START;
        end
        START:     state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    shown = last_rx;
    case (led_mode)
      LED_LAST:   shown = last_rx;
      LED_COUNT:  shown = 8'(count);
      LED_STATUS: shown = {overflow, full, empty, tx_busy, 1'b0, state};
      LED_PEEK:   shown = empty ? 8'h00 : pop_data;
      default:    shown = last_rx;
    endcase
  end

  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      last_rx <= 8'h00;
      led     <= 8'h00;
    end else begin
      if (rx_ready) last_rx <= rx_data;
      led <= bit_reverse(shown);
    end
  end
endmodule
